// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache SRAM write path: default geometry
// and the fill-sequencer state encoding.
package dcache_pkg;

    localparam int DEF_ADDR_WIDTH = 9;   // 512 words
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = 4;   // 8-bit bytes
    localparam int DEF_LINE_LOG2  = 3;   // 8 words per line

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage : dcache_pkg

// File: rtl/dcache_st_buf.sv
// Two-entry in-order store buffer holding {addr, data, byte enables}.
// Push is ignored when full and pop is ignored when empty, so the caller may
// drive them from simple request terms.
module dcache_st_buf
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DEF_BE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [BE_WIDTH-1:0]   push_be,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [BE_WIDTH-1:0]   head_be,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [ADDR_WIDTH-1:0] addr_mem [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic [BE_WIDTH-1:0]   be_mem   [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign count   = cnt;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign head_be   = be_mem[rd_ptr];

    // Pointer and occupancy tracking; a full buffer refuses a push even
    // when the head is leaving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
            be_mem[wr_ptr]   <= push_be;
        end
    end

endmodule : dcache_st_buf

// File: rtl/dcache_sram_wr_ctrl.sv
// Data-cache SRAM write arbiter. Line fills stream memory beats into the
// SRAM starting at the critical word and wrapping within the line; CPU
// store hits are queued in a small buffer and drained only while no fill
// is active, so a store to the line being filled always lands after the
// fill data. All SRAM write outputs come straight from flops.
module dcache_sram_wr_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DEF_BE_WIDTH,
    parameter int LINE_LOG2  = DEF_LINE_LOG2
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            fill_req,
    input  logic [ADDR_WIDTH-LINE_LOG2-1:0] fill_idx,
    input  logic [LINE_LOG2-1:0]            fill_crit,
    output logic                            fill_ready,
    output logic                            fill_done,
    input  logic                            mem_rvalid,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            mem_rready,
    input  logic                            st_valid,
    input  logic [ADDR_WIDTH-1:0]           st_addr,
    input  logic [DATA_WIDTH-1:0]           st_data,
    input  logic [BE_WIDTH-1:0]             st_be,
    output logic                            st_ready,
    output logic                            busy,
    output logic                            sram_wr_en,
    output logic [ADDR_WIDTH-1:0]           sram_wr_addr,
    output logic [DATA_WIDTH-1:0]           sram_wr_data,
    output logic [BE_WIDTH-1:0]             sram_wr_byte_en
);

    localparam int IDX_W = ADDR_WIDTH - LINE_LOG2;

    fill_state_e          state_q;
    fill_state_e          state_d;

    logic [IDX_W-1:0]     line_idx;
    logic [LINE_LOG2-1:0] crit_off;
    logic [LINE_LOG2-1:0] beat_cnt;
    logic [LINE_LOG2-1:0] word_off;

    logic                 fill_accept;
    logic                 beat_accept;
    logic                 last_beat;
    logic                 drain;
    logic                 st_push;

    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [BE_WIDTH-1:0]   buf_be;
    logic                  buf_full;
    logic                  buf_empty;
    logic [1:0]            buf_count;

    // Word within the line for the current beat, wrapping modulo line size.
    assign word_off = crit_off + beat_cnt;

    assign st_ready = ~buf_full;
    assign st_push  = st_valid & ~buf_full;
    assign busy     = (state_q == FILL) | (buf_count != 2'd0);

    dcache_st_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_st_buf (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .push       (st_push),
        .push_addr  (st_addr),
        .push_data  (st_data),
        .push_be    (st_be),
        .pop        (drain),
        .head_addr  (buf_addr),
        .head_data  (buf_data),
        .head_be    (buf_be),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    // Fill sequencer state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start a fill when one is accepted, finish on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_accept) state_d = FILL;
            FILL:    if (last_beat)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshakes and write arbitration; a fill accepted this cycle blocks the
    // store drain so the fill always wins.
    always_comb begin
        fill_ready  = (state_q == IDLE);
        mem_rready  = (state_q == FILL);
        fill_accept = fill_req & fill_ready;
        beat_accept = mem_rvalid & mem_rready;
        last_beat   = beat_accept & (beat_cnt == {LINE_LOG2{1'b1}});
        drain       = (state_q == IDLE) & ~fill_accept & ~buf_empty;
    end

    // Beat counter restarts on each accepted fill and wraps with the line.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt <= '0;
        end else if (fill_accept) begin
            beat_cnt <= '0;
        end else if (beat_accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Capture which line is being filled and where the first beat lands.
    always_ff @(posedge HCLK) begin
        if (fill_accept) begin
            line_idx <= fill_idx;
            crit_off <= fill_crit;
        end
    end

    // Registered SRAM write port; address/data/enables hold between writes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sram_wr_en      <= 1'b0;
            sram_wr_addr    <= '0;
            sram_wr_data    <= '0;
            sram_wr_byte_en <= '0;
            fill_done       <= 1'b0;
        end else begin
            fill_done <= last_beat;
            if (beat_accept) begin
                sram_wr_en      <= 1'b1;
                sram_wr_addr    <= {line_idx, word_off};
                sram_wr_data    <= mem_rdata;
                sram_wr_byte_en <= {BE_WIDTH{1'b1}};
            end else if (drain) begin
                sram_wr_en      <= 1'b1;
                sram_wr_addr    <= buf_addr;
                sram_wr_data    <= buf_data;
                sram_wr_byte_en <= buf_be;
            end else begin
                sram_wr_en      <= 1'b0;
            end
        end
    end

endmodule : dcache_sram_wr_ctrl
